fdn_column_engine: RTL and testbench

- Time-multiplexed finite-difference drum column: one shared fixed-point multiplier updates ROWS mesh nodes of one column per simulation step.
- Replaces one-multiplier-per-node instances when building large meshes.
- Columns sit side by side. East/west neighbours are read through a neighbour read port.
- Double-banked state keeps every column's reads at time n while it writes time n+1.

---
 rtl/fdn_pkg.sv | 31 +++
 rtl/fdn_column_engine_if.sv | 21 ++
 rtl/fdn_fx_mult.sv | 14 +
 rtl/fdn_column_engine.sv | 128 ++++++++++++
 tb/tb_fdn_column_engine.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/fdn_pkg.sv
// Shared fixed-point helpers and state encoding for the finite-difference mesh.
package fdn_pkg;

  localparam int FDN_WIDTH = 18;
  localparam int FDN_FRAC  = 16;
  localparam logic signed [63:0] ONE_FX = 64'sd1 <<< FDN_FRAC;

  typedef enum logic [2:0] {
    sCLEAR, sIDLE, sLAP, sMUL1, sMUL2, sWRITE, sDONE
  } state_t;

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

  // Signed product, arithmetic shift by frac (truncates toward -inf), saturated to w bits.
  function automatic logic signed [63:0] fx_mul(input logic signed [63:0] a,
                                                input logic signed [63:0] b,
                                                input int frac, input int w);
    logic signed [63:0] p;
    p = (a * b) >>> frac;
    return sat_w(p, w);
  endfunction

endpackage

// File: rtl/fdn_column_engine_if.sv
// Column engine control, coefficient, neighbour and read-back signals.
interface fdn_column_engine_if
  import fdn_pkg::*;
#(
  parameter int WIDTH = FDN_WIDTH,
  parameter int AW    = 5
);
  logic                    step_start, busy, step_done, init_we;
  logic signed [WIDTH-1:0] rho, eta, init_data, uEast, uWest, rd_u, u_tap;
  logic [AW-1:0]           init_row, nb_row, rd_row;

  modport master (
    output step_start, rho, eta, init_we, init_row, init_data, uEast, uWest, rd_row,
    input  busy, step_done, nb_row, rd_u, u_tap
  );

  modport slave (
    input  step_start, rho, eta, init_we, init_row, init_data, uEast, uWest, rd_row,
    output busy, step_done, nb_row, rd_u, u_tap
  );
endinterface

// File: rtl/fdn_fx_mult.sv
// Combinational signed fixed-point multiply: (a*b)>>>FRAC saturated to WIDTH.
module fdn_fx_mult
  import fdn_pkg::*;
#(
  parameter int WIDTH = FDN_WIDTH,
  parameter int FRAC  = FDN_FRAC,
  parameter int BW    = FDN_WIDTH + 3
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [BW-1:0]    b,
  output logic signed [WIDTH-1:0] p
);
  always_comb p = WIDTH'(fx_mul(64'(a), 64'(b), FRAC, WIDTH));
endmodule

// File: rtl/fdn_column_engine.sv
// One mesh column, ROWS nodes updated per step through a single shared multiplier.
module fdn_column_engine
  import fdn_pkg::*;
#(
  parameter int WIDTH   = FDN_WIDTH,
  parameter int FRAC    = FDN_FRAC,
  parameter int ROWS    = 32,
  parameter int AW      = 5,
  parameter int TAP_ROW = 16
) (
  input  logic              clk,
  input  logic              reset,
  fdn_column_engine_if.slave bus
);
  localparam int LW = WIDTH + 3;
  localparam logic [AW-1:0] LAST = AW'(ROWS - 1);
  localparam logic [AW-1:0] TAP  = AW'(TAP_ROW);

  typedef logic signed [WIDTH-1:0] w_t;
  typedef logic signed [LW-1:0]    l_t;

  w_t            mem [2][ROWS];
  state_t        state;
  logic          sel, busy_r, done_r;
  logic [AW-1:0] row, nb_r;
  w_t            rho_r, k_r, a_r, b_r, m_r;
  l_t            lap_r;

  w_t u_c, u_n, u_s, up_c, t_sat, k_c, ma, mp;
  l_t lap_c, t_c, mb;

  always_comb begin
    u_c   = mem[sel][row];
    up_c  = mem[~sel][row];
    u_n   = (row == '0)   ? '0 : mem[sel][row - AW'(1)];
    u_s   = (row == LAST) ? '0 : mem[sel][row + AW'(1)];
    lap_c = l_t'(u_n) + l_t'(u_s) + l_t'(bus.uEast) + l_t'(bus.uWest) - (l_t'(u_c) <<< 2);
    t_c   = l_t'(a_r) + (l_t'(u_c) <<< 1) - l_t'(b_r);
    t_sat = WIDTH'(sat_w(64'(t_c), WIDTH));
    k_c   = WIDTH'(sat_w((64'sd1 <<< FRAC) - (64'(bus.eta) >>> 1), WIDTH));
    // k*uprev is taken in sLAP while the multiplier is otherwise idle,
    // leaving sMUL1 for rho*lap and sMUL2 for the final k*t.
    case (state)
      sLAP:    begin ma = k_r;   mb = l_t'(up_c);  end
      sMUL1:   begin ma = rho_r; mb = lap_r;       end
      default: begin ma = k_r;   mb = l_t'(t_sat); end
    endcase
  end

  fdn_fx_mult #(.WIDTH(WIDTH), .FRAC(FRAC), .BW(LW)) u_mult (
    .a(ma), .b(mb), .p(mp)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= sCLEAR;
      sel    <= 1'b0;
      row    <= '0;
      nb_r   <= '0;
      busy_r <= 1'b1;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        sCLEAR: begin
          mem[0][row] <= '0;
          mem[1][row] <= '0;
          if (row == LAST) begin
            row    <= '0;
            busy_r <= 1'b0;
            state  <= sIDLE;
          end else begin
            row <= row + AW'(1);
          end
        end
        sIDLE: begin
          if (bus.init_we) mem[sel][bus.init_row] <= bus.init_data;
          if (bus.step_start) begin
            rho_r  <= bus.rho;
            k_r    <= k_c;
            row    <= '0;
            nb_r   <= '0;
            busy_r <= 1'b1;
            state  <= sLAP;
          end
        end
        sLAP: begin
          lap_r <= lap_c;
          b_r   <= mp;
          state <= sMUL1;
        end
        sMUL1: begin
          a_r   <= mp;
          state <= sMUL2;
        end
        sMUL2: begin
          m_r   <= mp;
          state <= sWRITE;
        end
        sWRITE: begin
          mem[~sel][row] <= m_r;
          // Bank swap and done pulse land together so readers see the new step at once.
          if (row == LAST) begin
            sel    <= ~sel;
            done_r <= 1'b1;
            state  <= sDONE;
          end else begin
            row   <= row + AW'(1);
            nb_r  <= row + AW'(1);
            state <= sLAP;
          end
        end
        sDONE: begin
          busy_r <= 1'b0;
          state  <= sIDLE;
        end
        default: state <= sCLEAR;
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.step_done = done_r;
  assign bus.nb_row    = nb_r;
  assign bus.rd_u      = mem[sel][bus.rd_row];
  assign bus.u_tap     = mem[sel][TAP];

endmodule

// File: tb/tb_fdn_column_engine.sv
// Directed vector bench for fdn_column_engine: one reset + one step per table row, plus protocol sequences.
module tb_fdn_column_engine;
  localparam int ROWS = 32;
  localparam int AW   = 5;
  localparam int LAT  = 4 * ROWS;  // edges after the start edge; done is high during cycle 4*ROWS+1

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fdn_column_engine_if #(.WIDTH(18), .AW(AW)) bus ();

  fdn_column_engine #(.WIDTH(18), .FRAC(16), .ROWS(ROWS), .AW(AW), .TAP_ROW(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  logic [17:0] east_v, west7_v;
  always_comb begin
    bus.uEast = east_v;
    bus.uWest = (bus.nb_row == 5'd7) ? west7_v : 18'h0;
  end

  int nchk = 0;
  int nerr = 0;
  int done_cnt = 0;
  always @(negedge clk) if (bus.step_done) done_cnt <= done_cnt + 1;

  typedef struct {
    logic [17:0]      rho, eta, east, west7;
    int               ni;
    logic [1:0][4:0]  ir;
    logic [1:0][17:0] iv;
    logic [17:0]      dflt;
    int               ne;
    logic [3:0][4:0]  er;
    logic [3:0][17:0] ev;
  } vec_t;

  function automatic vec_t mkv(logic [17:0] rho, eta, east, west7, int ni,
                               logic [4:0] i0r, logic [17:0] i0v, logic [4:0] i1r, logic [17:0] i1v,
                               logic [17:0] dflt, int ne,
                               logic [4:0] e0r, logic [17:0] e0v, logic [4:0] e1r, logic [17:0] e1v,
                               logic [4:0] e2r, logic [17:0] e2v, logic [4:0] e3r, logic [17:0] e3v);
    vec_t v;
    v.rho = rho; v.eta = eta; v.east = east; v.west7 = west7;
    v.ni = ni; v.ir[0] = i0r; v.iv[0] = i0v; v.ir[1] = i1r; v.iv[1] = i1v;
    v.dflt = dflt; v.ne = ne;
    v.er[0] = e0r; v.ev[0] = e0v; v.er[1] = e1r; v.ev[1] = e1v;
    v.er[2] = e2r; v.ev[2] = e2v; v.er[3] = e3r; v.ev[3] = e3v;
    return v;
  endfunction

  task automatic chk_u(input string nm, input logic [17:0] act, input logic [17:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic read_row(input int r, output logic [17:0] v);
    bus.rd_row = AW'(r);
    #1;
    v = bus.rd_u;
  endtask

  // Returns the number of edges busy stayed high after reset was released.
  task automatic do_reset(output int bcnt);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bcnt = 0;
    while (bus.busy && bcnt < 1000) begin
      @(negedge clk);
      bcnt++;
    end
  endtask

  task automatic init_write(input int r, input logic [17:0] v);
    @(negedge clk);
    bus.init_we = 1'b1; bus.init_row = AW'(r); bus.init_data = v;
    @(negedge clk);
    bus.init_we = 1'b0;
  endtask

  task automatic start_step(input logic [17:0] rho, input logic [17:0] eta);
    @(negedge clk);
    bus.rho = rho; bus.eta = eta; bus.step_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.step_start = 1'b0;
  endtask

  // Counts edges from the start edge until step_done is seen; timeout is a failure.
  task automatic wait_done(input int first, output int lat);
    lat = first;
    while (!bus.step_done && lat < 2000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.step_done) begin
      nchk++; nerr++;
      $display("FAIL step_done_timeout: got none, expected pulse");
    end
  endtask

  vec_t vt[7];
  logic [17:0] rv, exp;
  int bcnt, lat, dc0;

  initial begin
    bus.step_start = 0; bus.init_we = 0; bus.init_row = '0; bus.init_data = '0;
    bus.rho = '0; bus.eta = '0; bus.rd_row = '0;
    east_v = '0; west7_v = '0;

    //          rho       eta       east      west7     ni  i0r  i0v        i1r  i1v        dflt     ne  expected overrides
    vt[0] = mkv(18'h0,    18'h0,    18'h0,    18'h0,    1,  3,  18'h08000,  0,  18'h0,      18'h0,   1,  3, 18'h10000, 0, 0, 0, 0, 0, 0);
    vt[1] = mkv(18'h04000,18'h0,    18'h0,    18'h0,    1,  5,  18'h10000,  0,  18'h0,      18'h0,   3,  5, 18'h10000, 4, 18'h04000, 6, 18'h04000, 0, 0);
    vt[2] = mkv(18'h0,    18'h0,    18'h0,    18'h0,    1,  0,  18'h18000,  0,  18'h0,      18'h0,   1,  0, 18'h1FFFF, 0, 0, 0, 0, 0, 0);
    vt[3] = mkv(18'h0,    18'h0,    18'h0,    18'h0,    1,  0,  18'h28000,  0,  18'h0,      18'h0,   1,  0, 18'h20000, 0, 0, 0, 0, 0, 0);
    // k=0.75; 2*u = 2.0 saturates to 0x1FFFF before the k multiply, giving 0x17FFF.
    vt[4] = mkv(18'h0,    18'h08000,18'h0,    18'h0,    1,  31, 18'h10000,  0,  18'h0,      18'h0,   1,  31, 18'h17FFF, 0, 0, 0, 0, 0, 0);
    vt[5] = mkv(18'h04000,18'h0,    18'h0,    18'h0,    2,  0,  18'h10000,  31, 18'h10000,  18'h0,   4,  0, 18'h10000, 1, 18'h04000, 30, 18'h04000, 31, 18'h10000);
    vt[6] = mkv(18'h04000,18'h0,    18'h04000,18'h10000,0,  0,  18'h0,      0,  18'h0,      18'h01000,1, 7, 18'h05000, 0, 0, 0, 0, 0, 0);

    // Reset / clear
    do_reset(bcnt);
    chk_i("busy_clear_cycles", bcnt, ROWS);
    chk_u("step_done_after_reset", 18'(bus.step_done), 18'h0);
    for (int r = 0; r < ROWS; r++) begin
      read_row(r, rv);
      chk_u($sformatf("reset_row%0d", r), rv, 18'h0);
    end

    // Table vectors: reset, init, one step, full column compare
    for (int i = 0; i < 7; i++) begin
      do_reset(bcnt);
      east_v = vt[i].east; west7_v = vt[i].west7;
      for (int j = 0; j < vt[i].ni; j++) init_write(int'(vt[i].ir[j]), vt[i].iv[j]);
      start_step(vt[i].rho, vt[i].eta);
      wait_done(0, lat);
      chk_i($sformatf("v%0d_latency", i), lat, LAT);
      @(negedge clk);
      for (int r = 0; r < ROWS; r++) begin
        exp = vt[i].dflt;
        for (int k = 0; k < vt[i].ne; k++) if (int'(vt[i].er[k]) == r) exp = vt[i].ev[k];
        read_row(r, rv);
        chk_u($sformatf("v%0d_row%0d", i, r), rv, exp);
      end
    end
    east_v = '0; west7_v = '0;

    // Two consecutive free-motion steps use u(n-1)
    do_reset(bcnt);
    init_write(3, 18'h08000);
    start_step(18'h0, 18'h0);
    wait_done(0, lat);
    chk_i("free1_latency", lat, LAT);
    @(posedge clk); #1;
    chk_u("step_done_one_cycle", 18'(bus.step_done), 18'h0);
    @(negedge clk);
    read_row(3, rv);
    chk_u("free1_row3", rv, 18'h10000);
    start_step(18'h0, 18'h0);
    wait_done(0, lat);
    chk_i("free2_latency", lat, LAT);
    @(negedge clk);
    read_row(3, rv);
    chk_u("free2_row3", rv, 18'h18000);

    // Init and start while busy are ignored; tap stays put mid-step
    do_reset(bcnt);
    init_write(16, 18'h08000);
    dc0 = done_cnt;
    start_step(18'h0, 18'h0);
    repeat (3) @(negedge clk);
    bus.init_we = 1'b1; bus.init_row = 5'd9; bus.init_data = 18'h03000; bus.step_start = 1'b1;
    @(negedge clk);
    bus.init_we = 1'b0; bus.step_start = 1'b0;
    chk_u("tap_mid_step", bus.u_tap, 18'h08000);
    wait_done(5, lat);
    @(negedge clk);
    chk_u("tap_after_step", bus.u_tap, 18'h10000);
    read_row(9, rv);
    chk_u("busy_init_ignored", rv, 18'h0);
    repeat (3) @(negedge clk);
    chk_u("busy_start_ignored", 18'(bus.busy), 18'h0);
    chk_i("one_done_pulse", done_cnt - dc0, 1);

    // Reset in cycle 10 of a step: no done, both banks cleared
    do_reset(bcnt);
    init_write(0, 18'h08000);
    init_write(1, 18'h08000);
    dc0 = done_cnt;
    start_step(18'h0, 18'h0);
    repeat (9) @(negedge clk);
    do_reset(bcnt);
    chk_i("midstep_reset_clear", bcnt, ROWS);
    chk_i("midstep_reset_no_done", done_cnt - dc0, 0);
    for (int r = 0; r < ROWS; r++) begin
      read_row(r, rv);
      chk_u($sformatf("abort_row%0d", r), rv, 18'h0);
    end
    // A leftover 1.0 in the u(n-1) bank would show up as -1.0 here.
    start_step(18'h0, 18'h0);
    wait_done(0, lat);
    @(negedge clk);
    read_row(0, rv);
    chk_u("abort_prev_row0", rv, 18'h0);
    read_row(1, rv);
    chk_u("abort_prev_row1", rv, 18'h0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
